fpu_result_queue: RTL and testbench

- Downstream stage of the FPU divide/arith datapath; consumes the 32-bit result plus error and overflow flags each cycle a result is presented.
- Buffers results in a small FIFO with a valid/ready handshake toward the register-file writeback.
- Maintains sticky IEEE-754 exception flags: invalid, overflow, zero/underflow.
- Counts retired results.

---
 rtl/fpu_result_queue.sv | 128 ++++++++++++
 tb/tb_fpu_result_queue.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_result_queue.sv
// Result FIFO behind the FPU datapath: valid/ready buffering, sticky IEEE-754 flags, retire counter.
// Optional same-cycle empty-queue bypass enabled by defining FPU_RESQ_BYPASS_EN.
module fpu_result_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_result,
    input  logic                     in_error,
    input  logic                     in_overflow,
    input  logic [1:0]               in_op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_result,
    output logic                     out_error,
    output logic                     out_overflow,
    output logic [1:0]               out_op,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     flag_clear,
    output logic                     flag_invalid,
    output logic                     flag_overflow,
    output logic                     flag_zero,
    output logic [CNT_W-1:0]         retire_cnt
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = 36;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [ENTRY_W-1:0] storage [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [ENTRY_W-1:0] in_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic [ENTRY_W-1:0] shown_entry;
    logic               queue_valid;
    logic               accept;
    logic               bypass;
    logic               push;
    logic               pop_q;
    logic               retire;
    logic               set_invalid;
    logic               set_overflow;
    logic               set_zero;

    assign in_ready    = (count < FULL_COUNT);
    assign queue_valid = (count != '0);
    assign accept      = in_valid && in_ready;

`ifdef FPU_RESQ_BYPASS_EN
    // An empty queue with a waiting consumer hands the input straight through.
    assign bypass = !queue_valid && in_valid && out_ready;
`else
    assign bypass = 1'b0;
`endif

    assign push   = accept && !bypass;
    assign pop_q  = queue_valid && out_ready;
    assign retire = pop_q || bypass;

    assign in_entry   = {in_op, in_overflow, in_error, in_result};
    assign head_entry = storage[rd_ptr];

    assign set_invalid  = accept && in_error;
    assign set_overflow = accept && in_overflow;
    assign set_zero     = accept && !in_error && (in_result[30:0] == 31'd0);

    always_comb begin
        shown_entry = head_entry;
        if (bypass) begin
            shown_entry = in_entry;
        end
    end

    assign out_valid    = queue_valid || bypass;
    assign out_op       = shown_entry[35:34];
    assign out_overflow = shown_entry[33];
    assign out_error    = shown_entry[32];
    assign out_result   = shown_entry[31:0];

    // Storage is deliberately left unreset; out_valid masks stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            storage[wr_ptr] <= in_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_q) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop_q})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A set event in the same cycle as flag_clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_invalid  <= 1'b0;
            flag_overflow <= 1'b0;
            flag_zero     <= 1'b0;
            retire_cnt    <= '0;
        end else begin
            flag_invalid  <= (flag_invalid  && !flag_clear) || set_invalid;
            flag_overflow <= (flag_overflow && !flag_clear) || set_overflow;
            flag_zero     <= (flag_zero     && !flag_clear) || set_zero;
            if (retire) begin
                retire_cnt <= retire_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fpu_result_queue.sv
// Self-checking bench for fpu_result_queue: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_fpu_result_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    typedef struct packed {
        logic [1:0]  op;
        logic        ovf;
        logic        err;
        logic [31:0] res;
    } entry_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [31:0]            in_result;
    logic                   in_error;
    logic                   in_overflow;
    logic [1:0]             in_op;
    logic                   out_valid;
    logic                   out_ready;
    logic [31:0]            out_result;
    logic                   out_error;
    logic                   out_overflow;
    logic [1:0]             out_op;
    logic [$clog2(DEPTH):0] count;
    logic                   flag_clear;
    logic                   flag_invalid;
    logic                   flag_overflow;
    logic                   flag_zero;
    logic [CNT_W-1:0]       retire_cnt;

    int         vectors = 0;
    int         miscompares = 0;
    bit         check_en = 1'b0;
    entry_t     model_q[$];
    bit         m_inv;
    bit         m_ovf;
    bit         m_zero;
    logic [CNT_W-1:0] m_retire;
    logic       obs_out_valid;
    logic [31:0] obs_out_result;

    fpu_result_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_error(in_error), .in_overflow(in_overflow), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_error(out_error), .out_overflow(out_overflow), .out_op(out_op),
        .count(count), .flag_clear(flag_clear),
        .flag_invalid(flag_invalid), .flag_overflow(flag_overflow), .flag_zero(flag_zero),
        .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, compare combinational view at the falling edge, then advance the model.
    task automatic applyStimulus(input logic v, input logic [31:0] r, input logic e, input logic o,
                                 input logic [1:0] op, input logic ordy, input logic fclr,
                                 input logic rs);
        bit     exp_ready;
        bit     exp_valid;
        bit     bypass_case;
        bit     accepted;
        bit     popped;
        entry_t e_in;
        entry_t head;
        in_valid = v; in_result = r; in_error = e; in_overflow = o; in_op = op;
        out_ready = ordy; flag_clear = fclr; rst = rs;
        e_in = '{op: op, ovf: o, err: e, res: r};
        @(negedge clk);
        exp_ready = (model_q.size() < DEPTH);
`ifdef FPU_RESQ_BYPASS_EN
        bypass_case = (model_q.size() == 0) && v && ordy;
`else
        bypass_case = 1'b0;
`endif
        exp_valid = (model_q.size() != 0) || bypass_case;
        head = bypass_case ? e_in : ((model_q.size() != 0) ? model_q[0] : e_in);
        accepted = v && exp_ready;
        popped = exp_valid && ordy;
        obs_out_valid = out_valid;
        obs_out_result = out_result;
        if (check_en) begin
            checkOutput("in_ready", 64'(in_ready), 64'(exp_ready));
            checkOutput("out_valid", 64'(out_valid), 64'(exp_valid));
            checkOutput("count", 64'(count), 64'(model_q.size()));
            checkOutput("flag_invalid", 64'(flag_invalid), 64'(m_inv));
            checkOutput("flag_overflow", 64'(flag_overflow), 64'(m_ovf));
            checkOutput("flag_zero", 64'(flag_zero), 64'(m_zero));
            checkOutput("retire_cnt", 64'(retire_cnt), 64'(m_retire));
            if (exp_valid) begin
                checkOutput("head_entry", 64'({out_op, out_overflow, out_error, out_result}),
                            64'(head));
            end
        end
        @(posedge clk);
        #1;
        if (rs) begin
            model_q.delete();
            m_inv = 0; m_ovf = 0; m_zero = 0; m_retire = '0;
        end else begin
            if (popped && !bypass_case) void'(model_q.pop_front());
            if (accepted && !bypass_case) model_q.push_back(e_in);
            if (popped) m_retire = m_retire + 1'b1;
            m_inv  = (m_inv  && !fclr) || (accepted && e);
            m_ovf  = (m_ovf  && !fclr) || (accepted && o);
            m_zero = (m_zero && !fclr) || (accepted && !e && (r[30:0] == 31'd0));
        end
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        check_en = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rw;
        int sel;
        rst = 1'b1; in_valid = 0; in_result = '0; in_error = 0; in_overflow = 0;
        in_op = '0; out_ready = 0; flag_clear = 0;
        m_retire = '0;

        // Single push, then pop.
        doReset();
        checkOutput("reset_count", 64'(count), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        applyStimulus(1, 32'h3F800000, 0, 0, 2'd1, 0, 0, 0);
        checkOutput("t1_count", 64'(count), 64'd1);
        checkOutput("t1_result", 64'(out_result), 64'h3F800000);
        checkOutput("t1_op", 64'(out_op), 64'd1);
        applyStimulus(0, 32'h0, 0, 0, 2'd0, 1, 0, 0);
        checkOutput("t1_count_after_pop", 64'(count), 64'd0);
        checkOutput("t1_retire", 64'(retire_cnt), 64'd1);

        // Fill past full, then drain in order.
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(1, 32'h40000000 + 32'(i), 0, 0, 2'd2, 0, 0, 0);
        checkOutput("t2_count_full", 64'(count), 64'd4);
        checkOutput("t2_in_ready_full", 64'(in_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t2_drain_order", 64'(out_result), 64'(32'h40000000 + 32'(i)));
            applyStimulus(0, 32'h0, 0, 0, 2'd0, 1, 0, 0);
        end
        checkOutput("t2_empty", 64'(out_valid), 64'd0);

        // Steady push+pop at occupancy 2.
        doReset();
        applyStimulus(1, 32'h11110000, 0, 0, 2'd0, 0, 0, 0);
        applyStimulus(1, 32'h11110001, 0, 0, 2'd0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            checkOutput("t3_stream_order", 64'(out_result), 64'(32'h11110000 + 32'(i)));
            applyStimulus(1, 32'h11110002 + 32'(i), 0, 0, 2'(i), 1, 0, 0);
        end
        checkOutput("t3_count", 64'(count), 64'd2);
        checkOutput("t3_retire", 64'(retire_cnt), 64'd10);

        // Sticky flags and clear-vs-set priority.
        doReset();
        applyStimulus(1, 32'h7FC00000, 1, 0, 2'd3, 0, 0, 0);
        applyStimulus(1, 32'h7F800000, 0, 1, 2'd3, 0, 0, 0);
        applyStimulus(1, 32'h80000000, 0, 0, 2'd3, 0, 0, 0);
        checkOutput("t4_flags_set", 64'({flag_invalid, flag_overflow, flag_zero}), 64'b111);
        applyStimulus(1, 32'h7FC00001, 1, 0, 2'd0, 0, 1, 0);
        checkOutput("t4_flags_after_clear", 64'({flag_invalid, flag_overflow, flag_zero}), 64'b100);
        applyStimulus(1, 32'h00000000, 0, 0, 2'd0, 0, 0, 0);
        checkOutput("t4_reject_no_zero", 64'(flag_zero), 64'd0);

        // Reset in the middle of traffic.
        applyStimulus(0, 32'h0, 0, 0, 2'd0, 1, 0, 0);
        checkOutput("t5_count_pre", 64'(count), 64'd3);
        applyStimulus(1, 32'h12345678, 1, 1, 2'd1, 1, 1, 1);
        checkOutput("t5_count", 64'(count), 64'd0);
        checkOutput("t5_out_valid", 64'(out_valid), 64'd0);
        checkOutput("t5_flags", 64'({flag_invalid, flag_overflow, flag_zero}), 64'd0);
        checkOutput("t5_retire", 64'(retire_cnt), 64'd0);

        // Empty queue with consumer ready.
        applyStimulus(1, 32'h41200000, 0, 0, 2'd1, 1, 0, 0);
`ifdef FPU_RESQ_BYPASS_EN
        checkOutput("t6_same_cycle_valid", 64'(obs_out_valid), 64'd1);
        checkOutput("t6_same_cycle_result", 64'(obs_out_result), 64'h41200000);
        checkOutput("t6_count", 64'(count), 64'd0);
        checkOutput("t6_retire", 64'(retire_cnt), 64'd1);
`else
        checkOutput("t6_same_cycle_valid", 64'(obs_out_valid), 64'd0);
        checkOutput("t6_count", 64'(count), 64'd1);
        checkOutput("t6_next_result", 64'(out_result), 64'h41200000);
        applyStimulus(0, 32'h0, 0, 0, 2'd0, 1, 0, 0);
        checkOutput("t6_retire", 64'(retire_cnt), 64'd1);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            sel = int'($urandom_range(0, 7));
            case (sel)
                0:       rw = 32'h00000000;
                1:       rw = 32'h80000000;
                2:       rw = 32'h7FC00000;
                default: rw = $urandom;
            endcase
            applyStimulus(1'($urandom_range(0, 1)), rw, ($urandom_range(0, 5) == 0),
                          ($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 63) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
